uart_tx_arbiter: RTL and testbench

- Shares one uart_Tx instance between NUM_REQ byte producers using round-robin arbitration.
- Latches the winner's byte and drives the transmitter's send/Data_in handshake.
- Monitors busy/sent to report per-requester completion; a watchdog recovers from a stalled transmitter.
- Sits between client logic and uart_Tx; uart_Tx Data_out feeds the serial line unchanged.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_Tx between NUM_REQ byte producers.
// Drives the send/Data_in handshake, reports completion, and aborts stalled frames.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 3,
   parameter int TIMEOUT_CLKS = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 tx_send,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_sent,
   output logic [ID_W-1:0]      active_id,
   output logic                 error
);

   localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_SENT} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               tx_send_q, tx_send_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [ID_W-1:0]    active_id_q, active_id_d;
   logic               error_q, error_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic               any_req;
   logic [ID_W-1:0]    win;
   logic [ID_W-1:0]    rr_next;
   logic               wd_expire;

   // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_req && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            any_req = 1'b1;
            win     = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign rr_next   = (active_id_q == ID_W'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;
   assign wd_expire = (wdog_q == WD_W'(TIMEOUT_CLKS - 1));

   always_comb begin
      state_d     = state_q;
      grant_d     = '0;
      done_d      = '0;
      error_d     = 1'b0;
      tx_send_d   = tx_send_q;
      tx_data_d   = tx_data_q;
      active_id_d = active_id_q;
      wdog_d      = wdog_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         IDLE: begin
            // The cycle carrying done/error is not an arbitration cycle.
            if (any_req && !done_q && !error_q) begin
               grant_d[win] = 1'b1;
               tx_data_d    = req_data[8*win +: 8];
               active_id_d  = win;
               tx_send_d    = 1'b1;
               wdog_d       = '0;
               state_d      = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               tx_send_d = 1'b0;
               wdog_d    = '0;
               state_d   = WAIT_SENT;
            end else if (wd_expire) begin
               error_d   = 1'b1;
               tx_send_d = 1'b0;
               rr_ptr_d  = rr_next;
               wdog_d    = '0;
               state_d   = IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         WAIT_SENT: begin
            // tx_sent takes priority over a coincident watchdog expiry.
            if (tx_sent) begin
               done_d[active_id_q] = 1'b1;
               rr_ptr_d            = rr_next;
               wdog_d              = '0;
               state_d             = IDLE;
            end else if (wd_expire) begin
               error_d  = 1'b1;
               rr_ptr_d = rr_next;
               wdog_d   = '0;
               state_d  = IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         tx_send_q   <= 1'b0;
         tx_data_q   <= '0;
         active_id_q <= '0;
         error_q     <= 1'b0;
         wdog_q      <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         tx_send_q   <= tx_send_d;
         tx_data_q   <= tx_data_d;
         active_id_q <= active_id_d;
         error_q     <= error_d;
         wdog_q      <= wdog_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign tx_send   = tx_send_q;
   assign tx_data   = tx_data_q;
   assign active_id = active_id_q;
   assign error     = error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_Tx (2 clocks/bit, 10-bit frame).
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int IW  = 3;
   localparam int TO  = 32;
   localparam int CPB = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [7:0]    b;
   } exp_t;

   logic            clock = 1'b0;
   logic            reset;
   logic [NR-1:0]   req = '0;
   logic [8*NR-1:0] req_data = '0;
   logic [NR-1:0]   grant, done;
   logic            tx_send, tx_busy, tx_sent, error;
   logic [7:0]      tx_data;
   logic [IW-1:0]   active_id;
   logic            stall = 1'b0;

   int   checks = 0, errors = 0;
   int   gnt_seen = 0, done_seen = 0, err_seen = 0;
   int   cyc = 0, end_cyc = 0, send_run = 0, last_send_len = 0, n_ev = 0;
   logic end_vld = 1'b0;
   exp_t gnt_q[$];
   exp_t done_q[$];
   exp_t e;

   int        m_cnt;
   logic [7:0] m_byte;

   always #5 clock = ~clock;

   uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT_CLKS(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .tx_send(tx_send), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_sent(tx_sent), .active_id(active_id), .error(error)
   );

   // uart_Tx stand-in: busy the cycle after send, sent pulse when the frame ends.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_busy <= 1'b0;
         tx_sent <= 1'b0;
         m_cnt   <= 0;
         m_byte  <= '0;
      end else begin
         tx_sent <= 1'b0;
         if (tx_busy) begin
            if (m_cnt == 10*CPB - 1) begin
               tx_busy <= 1'b0;
               tx_sent <= 1'b1;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end else if (tx_send && !stall) begin
            tx_busy <= 1'b1;
            m_cnt   <= 0;
            m_byte  <= tx_data;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         send_run = 0;
         end_vld  = 1'b0;
      end else begin
         cyc++;
         if (tx_send) send_run++;
         else if (send_run != 0) begin
            last_send_len = send_run;
            send_run = 0;
         end
         n_ev = 0;
         if (grant != 0) n_ev++;
         if (done != 0) n_ev++;
         if (error) n_ev++;
         if (n_ev != 0) chk("excl", n_ev, 1);
         if (grant != 0) begin
            gnt_seen++;
            if (gnt_q.size() == 0) chk("gnt_unexp", 32'(grant), 0);
            else begin
               e = gnt_q.pop_front();
               chk("gnt", 32'(grant), 32'(1) << e.id);
               chk("gnt_data", 32'(tx_data), 32'(e.b));
               chk("gnt_id", 32'(active_id), 32'(e.id));
            end
            if (end_vld) chk("gnt_gap", 32'(cyc - end_cyc >= 2), 1);
            end_vld = 1'b0;
         end
         if (done != 0) begin
            done_seen++;
            if (done_q.size() == 0) chk("done_unexp", 32'(done), 0);
            else begin
               e = done_q.pop_front();
               chk("done", 32'(done), 32'(1) << e.id);
               chk("rx_byte", 32'(m_byte), 32'(e.b));
            end
            end_cyc = cyc;
            end_vld = 1'b1;
         end
         if (error) begin
            err_seen++;
            end_cyc = cyc;
            end_vld = 1'b1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   function automatic int seen(input int w);
      case (w)
         0:       return gnt_seen;
         1:       return done_seen;
         default: return err_seen;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int w, input int target, input int max);
      int i = 0;
      while (seen(w) < target && i < max) begin
         step(1);
         i++;
      end
      if (seen(w) < target) chk(tag, seen(w), target);
   endtask

   task automatic push(input int id, input logic [7:0] b, input logic to_done);
      exp_t x;
      x.id = IW'(id);
      x.b  = b;
      gnt_q.push_back(x);
      if (to_done) done_q.push_back(x);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int g0, d0, e0;
      reset = 1'b1;
      step(2);
      chk("rst_send", 32'(tx_send), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_id", 32'(active_id), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      reset = 1'b0;
      step(1);

      // single request
      g0 = gnt_seen; d0 = done_seen;
      req_data[23:16] = 8'hA5;
      push(2, 8'hA5, 1'b1);
      req = 4'b0100;
      wait_for("t1_gnt_to", 0, g0 + 1, 20);
      req = '0;
      wait_for("t1_done_to", 1, d0 + 1, 100);
      step(5);
      chk("t1_send_len", last_send_len, 2);
      chk("t1_done_cnt", done_seen - d0, 1);

      // simultaneous requests, held
      do_reset();
      g0 = gnt_seen; d0 = done_seen;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); push(3, 8'h44, 1'b1); push(0, 8'h11, 1'b1);
      req = 4'b1011;
      wait_for("t2_gnt_to", 0, g0 + 4, 400);
      req = '0;
      wait_for("t2_done_to", 1, d0 + 4, 200);
      step(5);
      chk("t2_gnt_cnt", gnt_seen - g0, 4);
      chk("t2_q_empty", gnt_q.size() + done_q.size(), 0);

      // fairness, all held
      do_reset();
      g0 = gnt_seen; d0 = done_seen;
      req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(17*i), 1'b1);
      req = 4'b1111;
      wait_for("t3_gnt_to", 0, g0 + 8, 800);
      req = '0;
      wait_for("t3_done_to", 1, d0 + 8, 200);
      step(5);
      chk("t3_q_empty", gnt_q.size() + done_q.size(), 0);

      // stalled transmitter
      do_reset();
      g0 = gnt_seen; d0 = done_seen; e0 = err_seen;
      stall = 1'b1;
      req_data = {8'h00, 8'h00, 8'h6B, 8'h5A};
      push(0, 8'h5A, 1'b0); push(1, 8'h6B, 1'b1);
      req = 4'b0011;
      wait_for("t4_gnt_to", 0, g0 + 1, 20);
      req = 4'b0010;
      wait_for("t4_err_to", 2, e0 + 1, 100);
      chk("t4_send_len", last_send_len, TO);
      chk("t4_no_done", done_seen - d0, 0);
      stall = 1'b0;
      wait_for("t4_gnt2_to", 0, g0 + 2, 20);
      req = '0;
      wait_for("t4_done_to", 1, d0 + 1, 100);
      step(5);
      chk("t4_err_cnt", err_seen - e0, 1);
      chk("t4_q_empty", gnt_q.size() + done_q.size(), 0);

      // withdrawn request
      do_reset();
      g0 = gnt_seen; d0 = done_seen;
      req_data = {8'h00, 8'h99, 8'h00, 8'h77};
      push(0, 8'h77, 1'b1);
      req = 4'b0001;
      wait_for("t5_gnt_to", 0, g0 + 1, 20);
      req = '0;
      step(5);
      req = 4'b0100;
      step(3);
      req = '0;
      wait_for("t5_done_to", 1, d0 + 1, 100);
      step(10);
      chk("t5_gnt_cnt", gnt_seen - g0, 1);

      // reset mid-frame
      do_reset();
      g0 = gnt_seen; d0 = done_seen;
      req_data = {8'h00, 8'h00, 8'hC3, 8'h3C};
      push(0, 8'h3C, 1'b0);
      req = 4'b0001;
      wait_for("t6_gnt_to", 0, g0 + 1, 20);
      req = '0;
      step(5);
      reset = 1'b1;
      #1;
      chk("t6_send", 32'(tx_send), 0);
      chk("t6_grant", 32'(grant), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_error", 32'(error), 0);
      step(2);
      done_q.delete();
      push(1, 8'hC3, 1'b1);
      req = 4'b0010;
      reset = 1'b0;
      wait_for("t6_gnt2_to", 0, g0 + 2, 20);
      req = '0;
      wait_for("t6_done_to", 1, d0 + 1, 100);
      step(5);
      chk("t6_done_cnt", done_seen - d0, 1);
      chk("t6_q_empty", gnt_q.size() + done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
